sram_rw0_initiator: RTL and testbench

- Initiator for the single-port RW0 behavioural SRAM macros (1-cycle registered-address read, byte/segment write mask).
- Converts a valid/ready request stream into RW0 port cycles and returns read data on a valid/ready response stream.
- Absorbs the fixed 1-cycle read latency and response backpressure.
- Optionally zero-fills the array after reset, so the cache arrays start in a defined state.

---
 rtl/sram_rw0_initiator.sv | 97 +++++++++
 tb/tb_sram_rw0_initiator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sram_rw0_initiator.sv
// sram_rw0_initiator: valid/ready front end for a single-port RW0 SRAM macro, with an optional post-reset fill sweep.
module sram_rw0_initiator #(
  parameter int                ADDR_W        = 10,
  parameter int                DEPTH         = 1024,
  parameter int                DATA_W        = 32,
  parameter int                MASK_W        = 4,
  parameter bit                INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_wmask,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              RW0_clk,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);
  typedef enum logic {INIT, RUN} state_t;
  localparam state_t            RST_STATE = INIT_ON_RESET ? INIT : RUN;
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic              run, init, hs, push, pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  always_comb begin
    state_d = (state_q == INIT && cnt_q == LAST) ? RUN : state_q;
    cnt_d   = (state_q == INIT && cnt_q != LAST) ? cnt_q + 1'b1 : cnt_q;
  end

  // Outputs are gated by reset_n so the macro sees no enable while reset is held.
  always_comb begin
    run        = reset_n && state_q == RUN;
    init       = reset_n && state_q == INIT;
    req_ready  = run && (req_write || ({1'b0, fcnt_q} + {2'b0, pend_q}) < 3'd2);
    hs         = req_valid && req_ready;
    init_done  = run;
    RW0_clk    = clock;
    RW0_en     = init || hs;
    RW0_wmode  = init || (hs && req_write);
    RW0_addr   = init ? cnt_q : req_addr;
    RW0_wmask  = init ? '1 : req_wmask;
    RW0_wdata  = init ? INIT_VALUE : req_wdata;
    resp_valid = fcnt_q != 2'd0;
    resp_rdata = mem_q[rptr_q];
  end

  // Read data is only valid the cycle after the enable, so it is captured right then.
  always_comb begin
    pend_d         = hs && !req_write;
    push           = pend_q;
    pop            = resp_valid && resp_ready;
    mem_d          = mem_q;
    mem_d[wptr_q]  = push ? RW0_rdata : mem_q[wptr_q];
    wptr_d         = wptr_q ^ push;
    rptr_d         = rptr_q ^ pop;
    fcnt_d         = fcnt_q + {1'b0, push} - {1'b0, pop};
  end
endmodule

// File: tb/tb_sram_rw0_initiator.sv
// tb_sram_rw0_initiator: directed bench for sram_rw0_initiator against a behavioural RW0 SRAM model.
module tb_sram_rw0_initiator;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam int          DW    = 32;
  localparam int          MW    = 4;
  localparam logic [31:0] IV    = 32'hA5A5A5A5;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
  logic [AW-1:0] req_addr = '0;
  logic [MW-1:0] req_wmask = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, resp_valid, init_done, RW0_clk, RW0_en, RW0_wmode;
  logic [DW-1:0] resp_rdata, RW0_wdata, RW0_rdata;
  logic [AW-1:0] RW0_addr;
  logic [MW-1:0] RW0_wmask;

  always #5 clock = ~clock;

  sram_rw0_initiator #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .MASK_W(MW),
                       .INIT_ON_RESET(1'b1), .INIT_VALUE(IV)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done), .RW0_clk(RW0_clk), .RW0_addr(RW0_addr), .RW0_en(RW0_en),
    .RW0_wmode(RW0_wmode), .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata));

  logic [DW-1:0] mem [DEPTH];
  always @(posedge RW0_clk)
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int i = 0; i < MW; i++)
          if (RW0_wmask[i]) mem[RW0_addr][i*8 +: 8] <= RW0_wdata[i*8 +: 8];
      end else
        RW0_rdata <= mem[RW0_addr];
    end

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [DW-1:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wmask = m; req_wdata = d;
    #1 check("wr_ready", req_ready, 1'b1);
    step;
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    int n = 0;
    exp_q.push_back(e);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    #1;
    while (!req_ready && n < 40) begin step; n++; end
    check("rd_accept", req_ready, 1'b1);
    step;
    req_valid = 1'b0;
  endtask

  always @(negedge clock)
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) check("resp_unexpected", resp_valid, 1'b0);
      else check("resp_data", resp_rdata, exp_q.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    repeat (2) step;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_en", RW0_en, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    reset_n = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      check("init_addr", 32'(RW0_addr), i);
      check("init_en", RW0_en, 1'b1);
      check("init_ready", req_ready, 1'b0);
      if (i == 0) begin
        check("init_wmode", RW0_wmode, 1'b1);
        check("init_wmask", 32'(RW0_wmask), 32'hF);
        check("init_wdata", RW0_wdata, IV);
        check("init_done_low", init_done, 1'b0);
      end
      step;
    end
    check("init_done_c17", init_done, 1'b1);
    check("run_ready", req_ready, 1'b1);
    // Streaming: writes then three reads held back to back
    wr(1, 4'hF, 32'h11111111);
    wr(2, 4'hF, 32'h22222222);
    wr(3, 4'hF, 32'h33333333);
    exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222); exp_q.push_back(32'h33333333);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 1;
    #1 check("st_ready_t0", req_ready, 1'b1); check("st_rv_t0", resp_valid, 1'b0);
    step; req_addr = 2;
    #1 check("st_ready_t1", req_ready, 1'b1); check("st_rv_t1", resp_valid, 1'b0);
    step; req_addr = 3;
    #1 check("st_ready_t2", req_ready, 1'b0); check("st_latency2", resp_valid, 1'b1);
    step;
    #1 check("st_ready_t3", req_ready, 1'b1); check("st_rv_t3", resp_valid, 1'b1);
    step; req_valid = 1'b0;
    repeat (4) step;
    check("st_drained", exp_q.size(), 0);
    // Backpressure
    resp_ready = 1'b0;
    exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222); exp_q.push_back(32'h33333333);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 1;
    #1 check("bp_ready_a0", req_ready, 1'b1);
    step; req_addr = 2;
    #1 check("bp_ready_a1", req_ready, 1'b1);
    step; req_addr = 3;
    #1 check("bp_ready_a2", req_ready, 1'b0);
    step;
    #1 check("bp_ready_a3", req_ready, 1'b0);
    req_write = 1'b1; req_addr = 9; req_wmask = 4'hF; req_wdata = 32'h99999999;
    #1 check("bp_write_ok", req_ready, 1'b1);
    step; req_write = 1'b0; req_addr = 3; resp_ready = 1'b1;
    #1 check("bp_no_pop_credit", req_ready, 1'b0);
    step;
    #1 check("bp_resume", req_ready, 1'b1);
    step; req_valid = 1'b0;
    repeat (4) step;
    check("bp_drained", exp_q.size(), 0);
    rd(9, 32'h99999999);
    // Masked write over init pattern
    wr(5, 4'b0101, 32'hFFFFFFFF);
    rd(5, 32'hA5FFA5FF);
    // Hazards: read-then-write and write-then-read on the same address
    exp_q.push_back(IV);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 7;
    #1 check("hz_rd7_ready", req_ready, 1'b1);
    step; req_write = 1'b1; req_wmask = 4'hF; req_wdata = 32'hDEADBEEF;
    #1 check("hz_wr7_ready", req_ready, 1'b1);
    step; req_addr = 8; req_wdata = 32'hCAFEF00D;
    #1 check("hz_wr8_ready", req_ready, 1'b1);
    exp_q.push_back(32'hCAFEF00D);
    step; req_write = 1'b0;
    #1 check("hz_rd8_ready", req_ready, 1'b1);
    step; req_valid = 1'b0;
    rd(7, 32'hDEADBEEF);
    repeat (4) step;
    check("hz_drained", exp_q.size(), 0);
    // Reset with one read pending and one FIFO entry
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 1;
    #1 check("mr_ready0", req_ready, 1'b1);
    step; req_addr = 2;
    #1 check("mr_ready1", req_ready, 1'b1);
    step; req_valid = 1'b0;
    #1 check("mr_one_entry", resp_valid, 1'b1);
    reset_n = 1'b0;
    #1 check("mr_resp_valid", resp_valid, 1'b0);
    check("mr_en", RW0_en, 1'b0);
    check("mr_ready", req_ready, 1'b0);
    check("mr_init_done", init_done, 1'b0);
    resp_ready = 1'b1;
    repeat (2) step;
    reset_n = 1'b1;
    #1 check("mr_sweep_addr0", 32'(RW0_addr), 0);
    check("mr_sweep_wr", RW0_wmode, 1'b1);
    k = 0;
    while (!init_done && k < 40) begin step; k++; end
    check("mr_sweep_len", k, DEPTH);
    rd(1, IV);
    rd(9, IV);
    repeat (4) step;
    check("final_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
